gf233_inv_seq: RTL and testbench

GF233_INV_SEQ -- requirements
Module: gf233_inv_seq

---
 rtl/gf233_pkg.sv | 53 +++++
 rtl/gf233_inv_seq_quadblk.sv | 23 ++
 rtl/gf233_inv_seq.sv | 133 +++++++++++++
 tb/tb_gf233_inv_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf233_pkg.sv
// Shared types and constants for the GF(2^233) Itoh-Tsujii inverter.
// Field squaring helper reduces modulo x^233 + x^74 + 1.
package gf233_pkg;

    localparam int W     = 233;
    localparam int RMID  = 74;
    localparam int QMAX  = 14;
    localparam int NSTEP = 9;

    typedef enum logic [2:0] {
        IDLE,
        SQA,
        G1,
        QUAD,
        MUL,
        FSQ,
        DONE
    } state_t;

    typedef struct packed {
        logic [5:0] shift;
        logic       use_b;
    } step_t;

    // use_b=1 multiplies by the pre-shift value, use_b=0 by g1
    localparam step_t STEPS [NSTEP] = '{
        '{6'd1,  1'b0},
        '{6'd1,  1'b0},
        '{6'd3,  1'b1},
        '{6'd1,  1'b0},
        '{6'd7,  1'b1},
        '{6'd14, 1'b1},
        '{6'd1,  1'b0},
        '{6'd29, 1'b1},
        '{6'd58, 1'b1}
    };

    function automatic logic [W-1:0] gf_sq(input logic [W-1:0] x);
        logic [2*W-2:0] s;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[2*i] = x[i];
        end
        for (int i = 2*W-2; i >= W; i--) begin
            if (s[i]) begin
                s[i-W+RMID] = ~s[i-W+RMID];
                s[i-W]      = ~s[i-W];
            end
        end
        return s[W-1:0];
    endfunction

endpackage

// File: rtl/gf233_inv_seq_quadblk.sv
// Quad block: d = a^(4^sel), sel in 1..14.
// Built as a chain of double squarings gated by sel.
module gf233_inv_seq_quadblk
    import gf233_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [3:0]   sel,
    output logic [W-1:0] d
);

    logic [W-1:0] t;

    always_comb begin
        t = a;
        for (int k = 1; k <= QMAX; k++) begin
            if (k <= int'(sel)) begin
                t = gf_sq(gf_sq(t));
            end
        end
        d = t;
    end

endmodule

// File: rtl/gf233_inv_seq.sv
// Sequential Itoh-Tsujii inverter over GF(2^233) with an
// external multiplier and an internal quad-block chain.
module gf233_inv_seq
    import gf233_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] inv_out,
    output logic         m_start,
    output logic [W-1:0] m_a,
    output logic [W-1:0] m_b,
    input  logic         m_done,
    input  logic [W-1:0] m_p
);

    state_t       state;
    state_t       nxt;
    logic [W-1:0] a_q;
    logic [W-1:0] g1_q;
    logic [W-1:0] b_q;
    logic [W-1:0] t_q;
    logic [5:0]   rem;
    logic [3:0]   idx;
    logic [3:0]   qsel;
    logic [W-1:0] qd;
    logic         last;

    assign last = (idx == 4'(NSTEP - 1));
    assign qsel = (rem > 6'(QMAX)) ? 4'(QMAX) : rem[3:0];

    gf233_inv_seq_quadblk quadblk (
        .a   (t_q),
        .sel (qsel),
        .d   (qd)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start)  nxt = SQA;
            SQA:     if (m_done) nxt = G1;
            G1:      if (m_done) nxt = QUAD;
            QUAD:    if (rem <= 6'(QMAX)) nxt = MUL;
            MUL:     if (m_done) nxt = last ? FSQ : QUAD;
            FSQ:     if (m_done) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        m_a = '0;
        m_b = '0;
        unique case (state)
            SQA: begin
                m_a = a_q;
                m_b = a_q;
            end
            G1: begin
                m_a = t_q;
                m_b = a_q;
            end
            MUL: begin
                m_a = t_q;
                m_b = STEPS[idx].use_b ? b_q : g1_q;
            end
            FSQ: begin
                m_a = t_q;
                m_b = t_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_start <= 1'b0;
        end else begin
            state   <= nxt;
            busy    <= (nxt != IDLE);
            done    <= (nxt == DONE);
            m_start <= (nxt != state)
                    && (nxt inside {SQA, G1, MUL, FSQ});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            g1_q    <= '0;
            b_q     <= '0;
            t_q     <= '0;
            rem     <= '0;
            idx     <= '0;
            inv_out <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) a_q <= a_in;
                SQA:  if (m_done) t_q <= m_p;
                G1: if (m_done) begin
                    g1_q <= m_p;
                    b_q  <= m_p;
                    t_q  <= m_p;
                    idx  <= '0;
                    rem  <= STEPS[0].shift;
                end
                QUAD: begin
                    t_q <= qd;
                    rem <= rem - {2'b00, qsel};
                end
                // b_q keeps the pre-shift value for the next step
                MUL: if (m_done) begin
                    t_q <= m_p;
                    b_q <= m_p;
                    if (!last) begin
                        idx <= idx + 4'd1;
                        rem <= STEPS[idx + 4'd1].shift;
                    end
                end
                FSQ: if (m_done) inv_out <= m_p;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf233_inv_seq.sv
// Randomized bench for gf233_inv_seq with a latency-programmable
// multiplier model and a shift-and-add field reference.
module tb_gf233_inv_seq;
    import gf233_pkg::*;

    localparam int NRAND = 300;
    localparam logic [232:0] POLY = (233'd1 << 74) | 233'd1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [232:0] a_in;
    logic         busy;
    logic         done;
    logic [232:0] inv_out;
    logic         m_start;
    logic [232:0] m_a;
    logic [232:0] m_b;
    logic         m_done;
    logic [232:0] m_p;

    gf233_inv_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .busy    (busy),
        .done    (done),
        .inv_out (inv_out),
        .m_start (m_start),
        .m_a     (m_a),
        .m_b     (m_b),
        .m_done  (m_done),
        .m_p     (m_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [232:0] got,
                       input logic [232:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [232:0] gmul(input logic [232:0] a,
                                          input logic [232:0] b);
        logic [232:0] r;
        logic [232:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < 233; i++) begin
            if (b[i]) r = r ^ x;
            x = x[232] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return r;
    endfunction

    function automatic int exp_lat(input int lm);
        return 1 + 12 * (lm + 1) + 15;
    endfunction

    function automatic logic [232:0] rnd233();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[232:0];
    endfunction

    function automatic logic [232:0] trace_model();
        int sh [9] = '{1, 1, 3, 1, 7, 14, 1, 29, 58};
        int n;
        logic [232:0] v;
        n = 0;
        v = '0;
        foreach (sh[i]) begin
            int r;
            r = sh[i];
            while (r > 0) begin
                int s;
                s = (r < 14) ? r : 14;
                v[4*n +: 4] = 4'(s);
                n++;
                r -= s;
            end
        end
        v[200 +: 8] = 8'(n);
        return v;
    endfunction

    logic [3:0] trace[$];

    always @(negedge clk) begin
        if (dut.state == QUAD) trace.push_back(dut.qsel);
    end

    function automatic logic [232:0] trace_obs();
        logic [232:0] v;
        v = '0;
        foreach (trace[i]) begin
            if (i < 15) v[4*i +: 4] = trace[i];
        end
        v[200 +: 8] = 8'(trace.size());
        return v;
    endfunction

    // multiplier model: m_done exactly lmv cycles after m_start
    int           lmv = 1;
    int           mcnt = 0;
    int           nstart = 0;
    int           ndone = 0;
    int           bad_stab = 0;
    bit           inj = 1'b0;
    logic [232:0] ca;
    logic [232:0] cb;

    initial begin
        m_done = 1'b0;
        m_p    = '0;
        ca     = '0;
        cb     = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (inj) begin
                m_done = 1'b1;
                m_p    = rnd233();
                inj    = 1'b0;
            end
            if (mcnt > 0) begin
                if (m_a !== ca || m_b !== cb) bad_stab++;
                mcnt--;
                if (mcnt == 0) begin
                    m_done = 1'b1;
                    m_p    = gmul(ca, cb);
                    ndone++;
                end
            end
            if (m_start) begin
                nstart++;
                ca   = m_a;
                cb   = m_b;
                mcnt = lmv;
            end
        end
    end

    task automatic run_op(input logic [232:0] a, input int lm,
                          input string tag);
        int c;
        int lat;
        bit got;
        lmv = lm;
        @(negedge clk);
        a_in     = a;
        start    = 1'b1;
        nstart   = 0;
        ndone    = 0;
        bad_stab = 0;
        trace.delete();
        c = cyc;
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        got   = 1'b0;
        lat   = -1;
        for (int k = 0; k < 1000 && !got; k++) begin
            if (done) begin
                got = 1'b1;
                lat = cyc - c;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, ":lat"}, 233'(lat), 233'(exp_lat(lm)));
        if (a == '0) chk({tag, ":inv0"}, inv_out, '0);
        else chk({tag, ":a*inv"}, gmul(a, inv_out), 233'd1);
        chk({tag, ":nmul"}, 233'(nstart), 233'(12));
        chk({tag, ":sel"}, trace_obs(), trace_model());
        chk({tag, ":stable"}, 233'(bad_stab), '0);
        @(negedge clk);
        chk({tag, ":pulse"}, {231'd0, busy, done}, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [232:0] a;
        int L;
        int nd;
        int nlow;
        int ex_low;
        int ex_done;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst:busy", {232'd0, busy}, '0);
        chk("rst:done", {232'd0, done}, '0);
        chk("rst:mstart", {232'd0, m_start}, '0);
        chk("rst:inv", inv_out, '0);
        rst_n = 1'b1;

        run_op(233'd1, 2, "one");
        chk("one:inv", inv_out, 233'd1);
        run_op(233'd0, 2, "zero");
        run_op(233'd2, 5, "x");

        // start held high: one operation per IDLE visit
        lmv = 1;
        L = exp_lat(1);
        a = rnd233() | 233'd1;
        @(negedge clk);
        a_in   = a;
        start  = 1'b1;
        nstart = 0;
        nd     = 0;
        nlow   = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) nlow++;
            if (done) begin
                nd++;
                chk("hold:a*inv", gmul(a, inv_out), 233'd1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 500 && busy; k++) @(negedge clk);
        ex_low  = 0;
        ex_done = 0;
        for (int t = 0; t < 100; t++) begin
            if (t % (L + 1) == 0) ex_low++;
            if (t % (L + 1) == L) ex_done++;
        end
        chk("hold:idle", 233'(nlow), 233'(ex_low));
        chk("hold:done", 233'(nd), 233'(ex_done));
        chk("hold:nmul", 233'(nstart), 233'(12 * ex_low));

        // reset during the step-8 quad passes
        lmv = 3;
        a = rnd233() | 233'd4;
        @(negedge clk);
        a_in  = a;
        start = 1'b1;
        ndone = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 1000 && ndone < 10; k++) @(negedge clk);
        @(negedge clk);
        chk("rst:inquad", 233'(dut.state), 233'(QUAD));
        rst_n = 1'b0;
        #1;
        chk("rst:busy2", {232'd0, busy}, '0);
        chk("rst:done2", {232'd0, done}, '0);
        chk("rst:mstart2", {232'd0, m_start}, '0);
        chk("rst:inv2", inv_out, '0);
        chk("rst:idle", 233'(dut.state), 233'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        inj   = 1'b1;
        repeat (3) @(negedge clk);
        chk("late:busy", {232'd0, busy}, '0);
        chk("late:mstart", {232'd0, m_start}, '0);
        chk("late:inv", inv_out, '0);
        run_op(a, 3, "rec");

        for (int i = 0; i < NRAND; i++) begin
            a = rnd233();
            if (a == '0) a = 233'd1;
            run_op(a, int'($urandom_range(1, 8)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
